// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: Moore FSM sequencing fetch/decode/execute,
// memory handshake stalls, illegal-opcode trap and a retired-instruction counter.
//   FETCH  | read instr at PC, PC += 4     MEMWB  | load data -> rt
//   DECODE | read regs, branch target       MEMWR  | store, waits for mem_ready
//   MEMADR | base + imm                     EXEC   | R-type ALU op
//   MEMRD  | load, waits for mem_ready      ALUWB  | ALU result -> rd
//   BRANCH | compare, PC = ALUOut if taken  ADDIEX | rs + imm
//   ADDIWB | ALU result -> rt               JUMP   | PC = jump target
//   TRAP   | illegal instruction, halted until reset
module multicycle_ctrl #(
    parameter bit          EXT_EN   = 1'b1,
    parameter bit          MEM_WAIT = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dest,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic             retired,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             is_sw_q, is_sw_d;
    logic             is_bne_q, is_bne_d;
    logic             retired_q;
    logic             halted_q;
    logic [CNT_W-1:0] count_q;
    logic             retire_d;
    logic             mem_rdy;
    logic [2:0]       alu_funct;
    logic             funct_ok;

    assign mem_rdy = MEM_WAIT ? mem_ready : 1'b1;

    always_comb begin
        alu_funct = 3'b000;
        funct_ok  = 1'b1;
        case (funct)
            6'b100000: alu_funct = 3'b010;
            6'b100010: alu_funct = 3'b110;
            6'b100100: alu_funct = 3'b000;
            6'b100101: alu_funct = 3'b001;
            6'b101010: alu_funct = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Opcode is only looked at in DECODE; the lw/sw and beq/bne choice is kept for later states.
    always_comb begin
        state_d  = state_q;
        is_sw_d  = is_sw_q;
        is_bne_d = is_bne_q;
        case (state_q)
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                is_sw_d  = (opcode == OP_SW);
                is_bne_d = (opcode == OP_BNE);
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = EXT_EN ? S_ADDIEX : S_TRAP;
                    OP_BNE:       state_d = EXT_EN ? S_BRANCH : S_TRAP;
                    OP_J:         state_d = EXT_EN ? S_JUMP : S_TRAP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_EXEC:   state_d = funct_ok ? S_ALUWB : S_TRAP;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Only final states ever move into FETCH from elsewhere.
    assign retire_d = (state_d == S_FETCH) && (state_q != S_FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            is_sw_q   <= 1'b0;
            is_bne_q  <= 1'b0;
            retired_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            is_sw_q   <= is_sw_d;
            is_bne_q  <= is_bne_d;
            retired_q <= retire_d;
            halted_q  <= (state_d == S_TRAP);
            if (retire_d) count_q <= count_q + CNT_ONE;
        end
    end

    assign retired     = retired_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

    always_comb begin
        mem_req     = 1'b0;
        i_or_d      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dest    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        pc_en       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req     = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = 3'b010;
                ir_write    = mem_rdy;
                pc_en       = mem_rdy;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = mem_rdy;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = alu_funct;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dest  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                pc_en       = is_bne_q ? ~zero : zero;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            mem_req   = 1'b0;
            ir_write  = 1'b0;
            pc_en     = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a full-featured instance and one with
// EXT_EN=0, CNT_W=4 run on shared stimulus; per-cycle expected control vectors.
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] JUNK    = 6'b111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] opcode = JUNK;
    logic [5:0] funct = JUNK;
    logic zero = 1'b0;
    logic mem_ready = 1'b1;

    logic mem_req_a, i_or_d_a, ir_write_a, mem_write_a, mem_to_reg_a, reg_dest_a;
    logic reg_write_a, alu_src_a_a, pc_en_a, retired_a, halted_a;
    logic [1:0] alu_src_b_a, pc_src_a;
    logic [2:0] alu_control_a;
    logic [15:0] instr_count_a;

    logic mem_req_b, i_or_d_b, ir_write_b, mem_write_b, mem_to_reg_b, reg_dest_b;
    logic reg_write_b, alu_src_a_b, pc_en_b, retired_b, halted_b;
    logic [1:0] alu_src_b_b, pc_src_b;
    logic [2:0] alu_control_b;
    logic [3:0] instr_count_b;

    always #5 clk = ~clk;

    multicycle_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req_a), .i_or_d(i_or_d_a),
        .ir_write(ir_write_a), .mem_write(mem_write_a), .mem_to_reg(mem_to_reg_a),
        .reg_dest(reg_dest_a), .reg_write(reg_write_a), .alu_src_a(alu_src_a_a),
        .alu_src_b(alu_src_b_a), .alu_control(alu_control_a), .pc_src(pc_src_a),
        .pc_en(pc_en_a), .retired(retired_a), .instr_count(instr_count_a),
        .halted(halted_a)
    );

    multicycle_ctrl #(.EXT_EN(1'b0), .MEM_WAIT(1'b1), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req_b), .i_or_d(i_or_d_b),
        .ir_write(ir_write_b), .mem_write(mem_write_b), .mem_to_reg(mem_to_reg_b),
        .reg_dest(reg_dest_b), .reg_write(reg_write_b), .alu_src_a(alu_src_a_b),
        .alu_src_b(alu_src_b_b), .alu_control(alu_control_b), .pc_src(pc_src_b),
        .pc_en(pc_en_b), .retired(retired_b), .instr_count(instr_count_b),
        .halted(halted_b)
    );

    logic [17:0] act_a, act_b;
    assign act_a = {mem_req_a, i_or_d_a, ir_write_a, mem_write_a, mem_to_reg_a, reg_dest_a,
                    reg_write_a, alu_src_a_a, alu_src_b_a, alu_control_a, pc_src_a,
                    pc_en_a, retired_a, halted_a};
    assign act_b = {mem_req_b, i_or_d_b, ir_write_b, mem_write_b, mem_to_reg_b, reg_dest_b,
                    reg_write_b, alu_src_a_b, alu_src_b_b, alu_control_b, pc_src_b,
                    pc_en_b, retired_b, halted_b};

    typedef struct {
        string       tag;
        logic [17:0] a;
        logic [17:0] b;
        int          ca;
        int          cb;
    } sb_t;

    sb_t sb_q[$];
    int  n_chk = 0;
    int  n_err = 0;
    bit  a_trap = 1'b0;
    bit  b_trap = 1'b0;
    bit  ret_p = 1'b0;
    int  cnt_a = 0;
    int  cnt_b = 0;

    function automatic logic [17:0] mk(input logic mreq, input logic iod, input logic irw,
                                       input logic mw, input logic m2r, input logic rd,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] ps,
                                       input logic pe, input logic ret, input logic hlt);
        return {mreq, iod, irw, mw, m2r, rd, rw, sa, sb, alu, ps, pe, ret, hlt};
    endfunction

    function automatic logic [17:0] v_fetch(input logic rdy, input logic ret);
        return mk(1, 0, rdy, 0, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, rdy, ret, 0);
    endfunction

    localparam logic [17:0] V_RSTHOLD = {8'b0, 2'b01, 3'b010, 2'b00, 3'b000};
    localparam logic [17:0] V_DEC     = {8'b0, 2'b11, 3'b010, 2'b00, 3'b000};
    localparam logic [17:0] V_MEMADR  = {8'b0000_0001, 2'b10, 3'b010, 2'b00, 3'b000};
    localparam logic [17:0] V_MEMRD   = {8'b1100_0000, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [17:0] V_MEMWB   = {8'b0000_1010, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [17:0] V_ALUWB   = {8'b0000_0110, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [17:0] V_ADDIWB  = {8'b0000_0010, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam logic [17:0] V_JUMP    = {8'b0000_0000, 2'b00, 3'b000, 2'b10, 3'b100};
    localparam logic [17:0] V_TRAP    = {8'b0000_0000, 2'b00, 3'b000, 2'b00, 3'b001};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expectation, compare on the falling edge.
    task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy, input logic [17:0] ev);
        sb_t e;
        opcode = op;
        funct = fn;
        zero = z;
        mem_ready = rdy;
        sb_q.push_back('{tag, a_trap ? V_TRAP : ev, b_trap ? V_TRAP : ev, cnt_a, cnt_b});
        @(negedge clk);
        e = sb_q.pop_front();
        check({e.tag, "_vec_a"}, {14'b0, act_a}, {14'b0, e.a});
        check({e.tag, "_vec_b"}, {14'b0, act_b}, {14'b0, e.b});
        check({e.tag, "_cnt_a"}, {16'b0, instr_count_a}, 32'(e.ca % 65536));
        check({e.tag, "_cnt_b"}, {28'b0, instr_count_b}, 32'(e.cb % 16));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic rdy);
        logic ret;
        ret = ret_p;
        if (ret_p) begin
            if (!a_trap) cnt_a++;
            if (!b_trap) cnt_b++;
            ret_p = 1'b0;
        end
        step("fetch", JUNK, JUNK, 1'b0, rdy, v_fetch(rdy, ret));
    endtask

    task automatic decode(input logic [5:0] op);
        step("decode", op, JUNK, 1'b0, 1'b1, V_DEC);
        if (op == OP_ADDI || op == OP_BNE || op == OP_J) b_trap = 1'b1;
        if (op == JUNK) begin
            a_trap = 1'b1;
            b_trap = 1'b1;
        end
    endtask

    task automatic do_r(input logic [5:0] fn, input logic [2:0] alu);
        fetch(1'b1);
        decode(OP_R);
        step("exec", JUNK, fn, 1'b0, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, alu, 2'b00, 0, 0, 0));
        step("aluwb", JUNK, JUNK, 1'b0, 1'b1, V_ALUWB);
        ret_p = 1'b1;
    endtask

    task automatic do_lw(input int stall);
        fetch(1'b1);
        decode(OP_LW);
        step("memadr_lw", OP_SW, JUNK, 1'b0, 1'b1, V_MEMADR);
        for (int i = 0; i < stall; i++) step("memrd_wait", OP_SW, JUNK, 1'b0, 1'b0, V_MEMRD);
        step("memrd", JUNK, JUNK, 1'b0, 1'b1, V_MEMRD);
        step("memwb", JUNK, JUNK, 1'b0, 1'b1, V_MEMWB);
        ret_p = 1'b1;
    endtask

    task automatic do_sw(input int stall);
        fetch(1'b1);
        decode(OP_SW);
        step("memadr_sw", OP_LW, JUNK, 1'b0, 1'b1, V_MEMADR);
        for (int i = 0; i < stall; i++)
            step("memwr_wait", JUNK, JUNK, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0));
        step("memwr", JUNK, JUNK, 1'b0, 1'b1, mk(1, 1, 0, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0));
        ret_p = 1'b1;
    endtask

    task automatic do_branch(input logic [5:0] op, input logic z, input logic taken);
        fetch(1'b1);
        decode(op);
        step("branch", OP_BEQ, JUNK, z, 1'b1, mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, taken, 0, 0));
        ret_p = 1'b1;
    endtask

    task automatic clear_model();
        a_trap = 1'b0;
        b_trap = 1'b0;
        ret_p = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step("reset_hold", JUNK, JUNK, 1'b0, 1'b1, V_RSTHOLD);
        rst_n = 1'b1;

        do_r(6'b100000, 3'b010);
        do_lw(3);
        fetch(1'b0);
        fetch(1'b0);
        do_sw(2);
        do_branch(OP_BEQ, 1'b0, 1'b0);
        do_branch(OP_BEQ, 1'b1, 1'b1);
        do_r(6'b100010, 3'b110);
        do_r(6'b100100, 3'b000);
        do_r(6'b100101, 3'b001);
        do_r(6'b101010, 3'b111);

        // addi diverges the two instances: EXT_EN=0 copy traps, the other runs on.
        fetch(1'b1);
        decode(OP_ADDI);
        step("addiex", JUNK, JUNK, 1'b0, 1'b1, V_MEMADR);
        step("addiwb", JUNK, JUNK, 1'b0, 1'b1, V_ADDIWB);
        ret_p = 1'b1;
        do_branch(OP_BNE, 1'b0, 1'b1);
        do_branch(OP_BNE, 1'b1, 1'b0);
        fetch(1'b1);
        decode(OP_J);
        step("jump", JUNK, JUNK, 1'b0, 1'b1, V_JUMP);
        ret_p = 1'b1;
        fetch(1'b1);
        decode(JUNK);
        for (int i = 0; i < 10; i++)
            step("trap_hold", 6'(i), OP_R, i[0], i[1], V_TRAP);

        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_model();

        for (int i = 0; i < 17; i++) do_r(6'b100000, 3'b010);
        fetch(1'b1);
        check("wrap_cnt_b", {28'b0, instr_count_b}, 32'd1);

        decode(OP_SW);
        step("memadr_sw", JUNK, JUNK, 1'b0, 1'b1, V_MEMADR);
        rst_n = 1'b0;
        step("memwr_rst", JUNK, JUNK, 1'b0, 1'b1, mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0));
        rst_n = 1'b1;
        clear_model();
        fetch(1'b1);
        decode(OP_R);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
